// File: rtl/acc_ctrl_seq.sv
// acc_ctrl_seq: decodes opcodes into accumulator-bank control beats. Loads and stores
// wait in MEM for mem_ready with a timeout. Optional macro: ACC_ILLEGAL_TRAP_EN.
module acc_ctrl_seq #(
   parameter int OPW         = 6,
   parameter int NACC        = 2,
   parameter int MEM_TIMEOUT = 15,
   localparam int SELW       = (NACC > 1) ? $clog2(NACC) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            op_valid,
   input  logic [OPW-1:0]  op,
   input  logic [SELW-1:0] acc_sel,
   output logic            op_ready,
   input  logic            mem_ready,
   input  logic            stall,
   output logic            mem_req,
   output logic            ctrl_valid,
   output logic [2:0]      acc_ctrl,
   output logic [NACC-1:0] acc_we,
   output logic            illegal,
   output logic            busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MEM  = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;
`ifdef ACC_ILLEGAL_TRAP_EN
   localparam logic [1:0] TRAP = 2'd3;
`endif
   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   logic [1:0]      state;
   logic [7:0]      tmo_cnt;
   logic [2:0]      beat_ctrl;
   logic [NACC-1:0] beat_we;
   logic            beat_ill;

   logic [2:0]      grp;
   logic [2:0]      sub;
   logic [2:0]      dec_ctrl;
   logic            dec_legal;
   logic            dec_we_en;
   logic            dec_mem;
   logic [NACC-1:0] sel_onehot;
   logic            sel_ok;
   logic            accept;

   assign grp = op[OPW-1 -: 3];
   assign sub = op[2:0];

   // Bank selects at or beyond NACC leave sel_ok low, which marks the opcode illegal.
   always_comb begin
      sel_onehot = '0;
      sel_ok     = 1'b0;
      for (int i = 0; i < NACC; i++) begin
         if (int'(acc_sel) == i) begin
            sel_onehot[i] = 1'b1;
            sel_ok        = 1'b1;
         end
      end
   end

   always_comb begin
      dec_ctrl  = 3'b000;
      dec_legal = 1'b1;
      dec_we_en = 1'b0;
      dec_mem   = 1'b0;
      case (grp)
         3'b000: begin
            if (sub <= 3'd3) begin
               dec_ctrl  = 3'b010;
               dec_we_en = 1'b1;
            end else if (sub == 3'd5 || sub == 3'd6) begin
               dec_ctrl  = 3'b001;
               dec_we_en = 1'b1;
            end else begin
               dec_legal = 1'b0;
            end
         end
         3'b001: begin
            if (sub == 3'd0) begin
               dec_ctrl  = 3'b000;
               dec_we_en = 1'b1;
               dec_mem   = 1'b1;
            end else if (sub == 3'd1) begin
               dec_ctrl  = 3'b001;
               dec_mem   = 1'b1;
            end else begin
               dec_legal = 1'b0;
            end
         end
         3'b010: begin
            dec_ctrl  = 3'b010;
            dec_we_en = 1'b1;
         end
         3'b011:  dec_legal = 1'b0;
         3'b100:  dec_ctrl  = 3'b000;
         3'b101:  dec_ctrl  = 3'b101;
         3'b110:  dec_ctrl  = 3'b001;
         default: dec_ctrl  = 3'b000;
      endcase
      if (!sel_ok) begin
         dec_legal = 1'b0;
      end
      // A rejected opcode never touches memory and always carries the all-zero beat.
      if (!dec_legal) begin
         dec_ctrl  = 3'b000;
         dec_we_en = 1'b0;
         dec_mem   = 1'b0;
      end
   end

`ifdef ACC_ILLEGAL_TRAP_EN
   // An illegal beat leaving OUT heads to TRAP, so no successor op can be taken then.
   assign op_ready = (state == IDLE) || (state == OUT && !stall && !beat_ill);
`else
   assign op_ready = (state == IDLE) || (state == OUT && !stall);
`endif

   assign accept = op_valid && op_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tmo_cnt   <= '0;
         beat_ctrl <= '0;
         beat_we   <= '0;
         beat_ill  <= 1'b0;
      end else if (accept) begin
         state     <= dec_mem ? MEM : OUT;
         tmo_cnt   <= '0;
         beat_ctrl <= dec_ctrl;
         beat_we   <= dec_we_en ? sel_onehot : '0;
         beat_ill  <= !dec_legal;
      end else begin
         case (state)
            MEM: begin
               if (mem_ready) begin
                  state   <= OUT;
                  tmo_cnt <= '0;
               end else if (tmo_cnt == TMO_LAST) begin
                  state     <= OUT;
                  tmo_cnt   <= '0;
                  beat_ctrl <= '0;
                  beat_we   <= '0;
                  beat_ill  <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            OUT: begin
               if (!stall) begin
`ifdef ACC_ILLEGAL_TRAP_EN
                  state <= beat_ill ? TRAP : IDLE;
`else
                  state <= IDLE;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   // Beat registers also hold the pending load/store result, so gate them by OUT.
   assign mem_req    = (state == MEM);
   assign ctrl_valid = (state == OUT);
   assign busy       = (state != IDLE);
   assign acc_ctrl   = ctrl_valid ? beat_ctrl : 3'b000;
   assign acc_we     = ctrl_valid ? beat_we : '0;
   assign illegal    = ctrl_valid && beat_ill;

endmodule

// File: doc/acc_ctrl_seq.md
ACC_CTRL_SEQ -- requirements
Module: acc_ctrl_seq

Interface
REQ-001 SHALL have parameter OPW, default 6: opcode width, minimum 6; the group field is op[OPW-1:OPW-3] and the sub field is op[2:0].
REQ-002 SHALL have parameter NACC, default 2: number of accumulator banks, 1..8; SELW = max(1, clog2(NACC)).
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15: maximum number of cycles spent waiting for mem_ready, range 1..255.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port op_valid, input, 1: an opcode is offered.
REQ-007 Port op, input, OPW: opcode.
REQ-008 Port acc_sel, input, SELW: target accumulator bank.
REQ-009 Port op_ready, output, 1: the block accepts op this cycle.
REQ-010 Port mem_ready, input, 1: the memory access is complete.
REQ-011 Port stall, input, 1: downstream cannot take the output beat.
REQ-012 Port mem_req, output, 1: memory access in progress.
REQ-013 Port ctrl_valid, output, 1: the output beat is valid.
REQ-014 Port acc_ctrl, output, 3: accumulator control code.
REQ-015 Port acc_we, output, NACC: one-hot accumulator write enable.
REQ-016 Port illegal, output, 1: the beat carries a rejected opcode.
REQ-017 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-018 SHALL decode acc_ctrl from the group and sub fields as follows.
- Group 000, sub 0-3: 010. Sub 5-6: 001. Other subs are illegal.
- Group 001, sub 0 (load): 000. Sub 1 (store): 001. Other subs are illegal.
- Group 010: 010. Group 100: 000. Group 110: 001. Group 111: 000. Group 101: 101.
- Group 011 is illegal.
REQ-019 SHALL set acc_we to one-hot(acc_sel) only for legal group 000, group 001 load, and group 010; otherwise acc_we SHALL be all zero.
REQ-020 SHALL treat acc_sel >= NACC as illegal for every opcode.
REQ-021 SHALL produce an illegal beat with acc_ctrl=000, acc_we=0 and illegal=1.
REQ-022 SHALL implement the FSM states IDLE, MEM, OUT and, when configured, TRAP.
REQ-023 SHALL drive op_ready = (IDLE) or (OUT and not stall); op_ready SHALL be 0 in MEM and TRAP.
REQ-024 SHALL accept an op when op_valid and op_ready; a non-memory op SHALL go to OUT with its beat registered (latency 1 cycle).
REQ-025 SHALL, on acceptance of a load or store, go to MEM with mem_req=1 from the next cycle.
- mem_req SHALL be held until mem_ready is sampled high.
- The state SHALL then go to OUT with the beat valid in the following cycle (latency = wait cycles + 2).
REQ-026 SHALL count the cycles spent in MEM; when the count reaches MEM_TIMEOUT without mem_ready, it SHALL drop mem_req and go to OUT with an illegal beat.
REQ-027 SHALL hold all outputs stable in OUT while stall=1.
REQ-028 SHALL, in OUT with stall=0, go to IDLE if no op is accepted; an accepted op SHALL replace the beat back-to-back (one op per cycle sustained).
REQ-029 SHALL treat mem_ready outside MEM as ignored; mem_ready in the same cycle mem_req first rises SHALL complete the access.

Reset
REQ-030 SHALL, while rst_n=0, immediately force:
- state=IDLE, timeout counter=0;
- mem_req=0, ctrl_valid=0, acc_ctrl=000, acc_we=0, illegal=0, busy=0.
REQ-031 SHALL abandon any in-flight memory op on reset, with no beat emitted afterwards.

Configuration
REQ-032 SHALL provide macro ACC_ILLEGAL_TRAP_EN.
- Defined: an illegal beat SHALL move the FSM, after the beat leaves OUT, to TRAP. TRAP has op_ready=0, busy=1 and ctrl_valid=0, and is exited only by reset.
- Undefined: an illegal beat SHALL be a normal one-beat event and the TRAP state SHALL not exist.

Verification
REQ-033 op=010_000, acc_sel=1, NACC=2, stall=0 -> the next cycle has ctrl_valid=1, acc_ctrl=010, acc_we=10, illegal=0.
REQ-034 Load op=001_000 with mem_ready high on the 3rd mem_req cycle -> mem_req high for 3 cycles, then ctrl_valid=1, acc_ctrl=000, acc_we one-hot.
REQ-035 Store with mem_ready never high, MEM_TIMEOUT=4 -> mem_req high for 4 cycles, then a beat with illegal=1 and acc_we=0.
REQ-036 Beat issued with stall=1 for 3 cycles and a new op_valid present -> outputs frozen and op_ready=0 for 3 cycles, then the new beat the next cycle.
REQ-037 op=011_000 -> illegal=1; with ACC_ILLEGAL_TRAP_EN, op_ready stays 0 until rst_n pulses low, then returns to 1.
REQ-038 rst_n low mid-MEM -> mem_req and busy go to 0 asynchronously, and no beat appears after release.
